// File: rtl/bcd_serial_accumulator.sv
// Digit-serial BCD adder: one digit per clock through a single BCD adder cell,
// least-significant digit first, with valid/ready handshakes on both sides.

module bcd_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [4:0] bin_s;

    assign bin_s = {1'b0, a_i} + {1'b0, b_i} + {4'd0, c_i};

    // Decimal correction: binary sums above 9 get +6 and produce a carry
    always_comb begin
        if (bin_s > 5'd9) begin
            s_o = bin_s[3:0] + 4'd6;
            c_o = 1'b1;
        end else begin
            s_o = bin_s[3:0];
            c_o = 1'b0;
        end
    end

endmodule

module bcd_serial_accumulator #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS-1:0]   operand_a,
    input  logic [4*NDIGITS-1:0]   operand_b,
    input  logic                   carry_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   sum,
    output logic                   carry_out,
    output logic                   digit_err
);

    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDXW-1:0]      idx_q;
    logic [4*NDIGITS-1:0] a_q;
    logic [4*NDIGITS-1:0] b_q;
    logic                 carry_q;
    logic [4*NDIGITS-1:0] sum_q;
    logic                 carry_out_q;
    logic                 digit_err_q;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic [3:0]           dig_a_s;
    logic [3:0]           dig_b_s;
    logic [3:0]           cell_sum_s;
    logic                 cell_carry_s;
    logic                 bad_digit_s;

    // Select the current digit pair from the captured operands
    always_comb begin
        dig_a_s     = a_q[{idx_q, 2'b00} +: 4];
        dig_b_s     = b_q[{idx_q, 2'b00} +: 4];
        bad_digit_s = (dig_a_s > 4'd9) | (dig_b_s > 4'd9);
    end

    bcd_adder u_bcd_adder (
        .a_i (dig_a_s),
        .b_i (dig_b_s),
        .c_i (carry_q),
        .s_o (cell_sum_s),
        .c_o (cell_carry_s)
    );

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            digit_err_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q         <= operand_a;
                        b_q         <= operand_b;
                        carry_q     <= carry_in;
                        sum_q       <= '0;
                        digit_err_q <= 1'b0;
                        idx_q       <= '0;
                        in_ready_q  <= 1'b0;
                        state_q     <= ADD;
                    end else begin
                        in_ready_q  <= 1'b1;
                    end
                end
                ADD: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= cell_sum_s;
                    carry_q     <= cell_carry_s;
                    digit_err_q <= digit_err_q | bad_digit_s;
                    // idx saturates at the top digit instead of wrapping
                    if (idx_q == LAST_IDX) begin
                        carry_out_q <= cell_carry_s;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q       <= idx_q + {{(IDXW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign digit_err = digit_err_q;

endmodule
